// File: rtl/status_conditioner.sv
// status_conditioner: synchronizes, debounces and latches the field fault contacts and
// generates the sample tick. First-fault capture is built only when STATUS_FIRST_FAULT_EN is defined.
module status_conditioner #(
    parameter int N_CH     = 7,
    parameter int CLK_DIV  = 781250,
    parameter int DEBOUNCE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_raw,
    input  logic            i_ack,
    output logic            o_tick,
    output logic [N_CH-1:0] o_status,
    output logic [N_CH-1:0] o_fault_latched,
    output logic            o_any_fault,
    output logic [N_CH-1:0] o_first_fault,
    output logic            o_first_valid
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DB_ONE   = DW'(1);

    logic [N_CH-1:0]         sync_meta;
    logic [N_CH-1:0]         sync_q;
    logic [PW-1:0]           pre_cnt;
    logic                    tick;
    logic [N_CH-1:0][DW-1:0] db_cnt;
    logic [N_CH-1:0][DW-1:0] db_cnt_next;
    logic [N_CH-1:0]         status_next;
    logic [N_CH-1:0]         rise;
    logic [N_CH-1:0]         ack_clear;
    logic [N_CH-1:0]         latched_next;

    // Two-flop synchronizer for the asynchronous field contacts.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= i_raw;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick   = (pre_cnt == PRE_LAST);
    assign o_tick = tick;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status_next = o_status;
        db_cnt_next = db_cnt;
        rise        = '0;
        if (tick) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (sync_q[ch] == o_status[ch]) begin
                    db_cnt_next[ch] = '0;
                end else if (db_cnt[ch] == DB_LAST) begin
                    status_next[ch] = ~o_status[ch];
                    db_cnt_next[ch] = '0;
                    rise[ch]        = ~o_status[ch];
                end else begin
                    db_cnt_next[ch] = db_cnt[ch] + DB_ONE;
                end
            end
        end
    end

    // An ack only releases channels whose debounced contact is already back to normal.
    assign ack_clear    = {N_CH{i_ack}} & ~o_status;
    assign latched_next = rise | (o_fault_latched & ~ack_clear);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt          <= '0;
            o_status        <= '0;
            o_fault_latched <= '0;
            o_any_fault     <= 1'b0;
        end else begin
            db_cnt          <= db_cnt_next;
            o_status        <= status_next;
            o_fault_latched <= latched_next;
            o_any_fault     <= |o_fault_latched;
        end
    end

`ifdef STATUS_FIRST_FAULT_EN
    // The capture freezes on the first rise; it is released only once the plant is fully quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_first_fault <= '0;
            o_first_valid <= 1'b0;
        end else if (!o_first_valid && (|rise)) begin
            o_first_fault <= rise;
            o_first_valid <= 1'b1;
        end else if (i_ack && !(|rise) && !(|o_status)) begin
            o_first_fault <= '0;
            o_first_valid <= 1'b0;
        end
    end
`else
    assign o_first_fault = '0;
    assign o_first_valid = 1'b0;
`endif

endmodule

// File: tb/tb_status_conditioner.sv
// tb_status_conditioner: directed scenarios with literal expectations plus randomized
// contact/ack/reset traffic compared every cycle against a behavioural model.
module tb_status_conditioner;

    localparam int N_CH     = 7;
    localparam int CLK_DIV  = 4;
    localparam int DEBOUNCE = 3;
`ifdef STATUS_FIRST_FAULT_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            ack   = 1'b0;
    logic [N_CH-1:0] raw   = '0;
    logic            o_tick;
    logic [N_CH-1:0] o_status;
    logic [N_CH-1:0] o_fault_latched;
    logic            o_any_fault;
    logic [N_CH-1:0] o_first_fault;
    logic            o_first_valid;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    int idx;

    status_conditioner #(.N_CH(N_CH), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .i_raw           (raw),
        .i_ack           (ack),
        .o_tick          (o_tick),
        .o_status        (o_status),
        .o_fault_latched (o_fault_latched),
        .o_any_fault     (o_any_fault),
        .o_first_fault   (o_first_fault),
        .o_first_valid   (o_first_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: contacts seen two clocks late, sampled every CLK_DIV-th cycle;
    // a status flips after DEBOUNCE consecutive samples that disagree with it.
    logic [N_CH-1:0] m_s1 = '0, m_s2 = '0, m_status = '0, m_latched = '0, m_ff = '0;
    logic [N_CH-1:0] m_rise, m_new_status;
    logic            m_any = 1'b0, m_fv = 1'b0;
    int              m_phase = 0;
    int              m_streak[N_CH];

    initial begin
        for (int ch = 0; ch < N_CH; ch++) m_streak[ch] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_status = '0; m_latched = '0; m_ff = '0;
                m_any = 1'b0; m_fv = 1'b0; m_phase = 0;
                for (int ch = 0; ch < N_CH; ch++) m_streak[ch] = 0;
            end else begin
                m_rise       = '0;
                m_new_status = m_status;
                if (m_phase == CLK_DIV - 1) begin
                    for (int ch = 0; ch < N_CH; ch++) begin
                        if (m_s2[ch] != m_status[ch]) begin
                            m_streak[ch] = m_streak[ch] + 1;
                            if (m_streak[ch] == DEBOUNCE) begin
                                m_new_status[ch] = ~m_status[ch];
                                m_rise[ch]       = m_new_status[ch];
                                m_streak[ch]     = 0;
                            end
                        end else begin
                            m_streak[ch] = 0;
                        end
                    end
                end
                m_any = |m_latched;
                for (int ch = 0; ch < N_CH; ch++)
                    m_latched[ch] = m_rise[ch] | (m_latched[ch] & !(ack && !m_status[ch]));
                if (FF_EN) begin
                    if (!m_fv && m_rise != '0) begin
                        m_ff = m_rise; m_fv = 1'b1;
                    end else if (ack && m_rise == '0 && m_status == '0) begin
                        m_ff = '0; m_fv = 1'b0;
                    end
                end
                m_status = m_new_status;
                m_phase  = (m_phase + 1) % CLK_DIV;
                m_s2     = m_s1;
                m_s1     = raw;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("tick",    32'(o_tick),          32'(m_phase == CLK_DIV - 1));
                check("status",  32'(o_status),        32'(m_status));
                check("latched", 32'(o_fault_latched), 32'(m_latched));
                check("any",     32'(o_any_fault),     32'(m_any));
                check("first",   32'(o_first_fault),   32'(m_ff));
                check("fvalid",  32'(o_first_valid),   32'(m_fv));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_status(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] val,
                               input int bound, input string name);
        for (int i = 0; i < bound && (o_status & mask) != val; i++) cycles(1);
        check(name, 32'(o_status & mask), 32'(val));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        cycles(2);
        rst_n = 1'b1;

        // Reset and tick: strobe on cycles 3, 7, 11 with everything else quiet.
        for (int k = 0; k < 12; k++) begin
            check("lit_tick", 32'(o_tick), 32'(k % CLK_DIV == CLK_DIV - 1));
            cycles(1);
        end
        check("lit_idle_status", 32'(o_status), 32'h0);
        check("lit_idle_latched", 32'(o_fault_latched), 32'h0);
        check("lit_idle_any", 32'(o_any_fault), 32'h0);

        // Fault qualification: ticks 3, 7, 11 sample the synchronized fault, status rises at cycle 12.
        do_reset();
        raw[2] = 1'b1;
        cycles(11);
        check("lit_q_pre", 32'(o_status), 32'h0);
        cycles(1);
        check("lit_q_status", 32'(o_status), 32'h04);
        check("lit_q_latched", 32'(o_fault_latched), 32'h04);
        check("lit_q_first", 32'(o_first_fault), FF_EN ? 32'h04 : 32'h0);
        check("lit_q_fvalid", 32'(o_first_valid), 32'(FF_EN));
        check("lit_q_any_lag", 32'(o_any_fault), 32'h0);
        cycles(1);
        check("lit_q_any", 32'(o_any_fault), 32'h1);

        // Ack held while the fault is still active changes nothing.
        ack = 1'b1;
        cycles(3);
        ack = 1'b0;
        check("lit_ack_active_latched", 32'(o_fault_latched), 32'h04);
        check("lit_ack_active_first", 32'(o_first_fault), FF_EN ? 32'h04 : 32'h0);

        // Fault clears, then ack releases latch, any-fault and capture.
        raw[2] = 1'b0;
        wait_status(7'b0000100, 7'b0000000, 40, "wait_clear");
        check("lit_clear_latched_kept", 32'(o_fault_latched), 32'h04);
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
        check("lit_ack_latched", 32'(o_fault_latched), 32'h0);
        check("lit_ack_fvalid", 32'(o_first_valid), 32'h0);
        check("lit_ack_first", 32'(o_first_fault), 32'h0);
        cycles(1);
        check("lit_ack_any", 32'(o_any_fault), 32'h0);

        // Two glitches, each exactly two tick samples long, never qualify.
        for (int g = 0; g < 2; g++) begin
            raw[5] = 1'b1;
            cycles(2 * CLK_DIV);
            raw[5] = 1'b0;
            cycles(3 * CLK_DIV);
        end
        check("lit_glitch_status", 32'(o_status), 32'h0);
        check("lit_glitch_latched", 32'(o_fault_latched), 32'h0);

        // Simultaneous faults are both captured; a later fault only latches.
        raw[0] = 1'b1;
        raw[6] = 1'b1;
        wait_status(7'b1000001, 7'b1000001, 40, "wait_sim");
        check("lit_sim_status", 32'(o_status), 32'h41);
        check("lit_sim_latched", 32'(o_fault_latched), 32'h41);
        check("lit_sim_first", 32'(o_first_fault), FF_EN ? 32'h41 : 32'h0);
        raw[3] = 1'b1;
        wait_status(7'b0001000, 7'b0001000, 40, "wait_later");
        check("lit_later_latched", 32'(o_fault_latched), 32'h49);
        check("lit_later_first", 32'(o_first_fault), FF_EN ? 32'h41 : 32'h0);

        // Reset after two differing ticks discards the count; three fresh samples are needed.
        raw = '0;
        do_reset();
        raw[1] = 1'b1;
        cycles(8);
        check("lit_mid_pre", 32'(o_status), 32'h0);
        do_reset();
        cycles(11);
        check("lit_mid_after_11", 32'(o_status), 32'h0);
        cycles(1);
        check("lit_mid_status", 32'(o_status), 32'h02);
        check("lit_mid_latched", 32'(o_fault_latched), 32'h02);

        // Randomized contacts, acks and occasional resets against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 23) == 0) begin
                idx = int'($urandom_range(0, N_CH - 1));
                raw[idx] = ~raw[idx];
            end
            ack = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                cycles(int'($urandom_range(1, 3)));
                rst_n = 1'b1;
            end
            cycles(1);
        end
        ack = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_conditioner.md
# status_conditioner

Input conditioning stage directly upstream of the cathode-supply interlock card. It synchronizes and debounces the seven raw field status contacts (card position, air grid, water anode, water grid, DC PS, U_CA low, I_CA high) and generates the 64 Hz sample tick used by the interlock timers. It also latches each fault until the operator acknowledges it. Its clean status bits feed the card's status NOR.

## Interface
- `N_CH`, default 7: number of status channels.
- `CLK_DIV`, default 781250: clk cycles per sample tick (50 MHz → 64 Hz); legal ≥ 2.
- `DEBOUNCE`, default 4: consecutive differing tick samples required to change a status bit; legal ≥ 1.

Ports:
- `clk` in 1: single system clock; all logic in this one domain.
- `reset` in 1: asynchronous, active-low reset.
- `i_raw` in N_CH: raw contacts, asynchronous; 1 = fault.
- `i_ack` in 1: operator acknowledge, synchronous, level-sampled each cycle.
- `o_tick` out 1: one-cycle sample strobe.
- `o_status` out N_CH: debounced status; 1 = fault.
- `o_fault_latched` out N_CH: sticky fault per channel.
- `o_any_fault` out 1: OR of `o_fault_latched`.
- `o_first_fault` out N_CH: channel(s) that faulted first.
- `o_first_valid` out 1: `o_first_fault` holds a capture.

## Operation
- **Synchronizer.** Each `i_raw` bit passes through 2 flops to give `sync[ch]`.
- **Prescaler.**
  - Counter width is $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps to 0.
  - `o_tick` = 1 in the cycle the counter equals CLK_DIV-1, so the tick period is exactly CLK_DIV cycles.
- **Debounce.** Each channel has a counter of width $clog2(DEBOUNCE+1). It is evaluated only on cycles where `o_tick` = 1:
  - If `sync[ch]` == `o_status[ch]`: the counter clears.
  - Else, if counter == DEBOUNCE-1: `o_status[ch]` toggles and the counter clears.
  - Else: the counter increments.
  - With no tick, the counter holds. The counter never exceeds DEBOUNCE-1.
- **Rise event.** `rise[ch]` = the debounce stage toggles `o_status[ch]` from 0 to 1 in this cycle (combinational, same tick cycle).
- **Fault latch.**
  - `rise[ch]` sets `o_fault_latched[ch]`.
  - `i_ack` clears it only if `o_status[ch]` == 0.
  - Set wins over clear in the same cycle.
  - A fault that is still active stays latched through any number of acks.
- **`o_any_fault`** is registered and updates the cycle after `o_fault_latched`.
- **First-fault capture.**
  - While `o_first_valid` = 0 and any `rise` bit is set: `o_first_fault` ← `rise` and `o_first_valid` ← 1. Simultaneous rises are all captured.
  - While `o_first_valid` = 1, later rises are ignored.
  - `i_ack` clears both only in a cycle with no `rise` bit set and with `o_status` all 0. Otherwise the ack is ignored for the capture.

## Timing
- Reset values: all outputs 0, including the prescaler, the debounce counters and the sync flops. Reset asserted mid-operation discards any pending debounce count and all latches immediately.
- First tick after reset release: cycle CLK_DIV-1.
- Raw-to-status latency: 2 synchronizer cycles, plus the wait for the next tick, plus (DEBOUNCE-1) further ticks. `o_status` changes in the cycle after the DEBOUNCE-th consecutive differing tick.
- A glitch shorter than DEBOUNCE consecutive tick samples never changes `o_status`.
- `o_fault_latched` and `o_first_fault` update in the same cycle as the `o_status` rise (all registered off the same tick edge).
- `i_ack` acts in the cycle it is sampled high; there is no handshake or pulse requirement, and holding it high acts every cycle.

## Configuration
- `STATUS_FIRST_FAULT_EN` defined: first-fault capture logic is present as described.
- Not defined: the capture logic is removed; `o_first_fault` is tied to 0 and `o_first_valid` is tied to 0. All other behaviour is unchanged.

## Test plan
All scenarios use CLK_DIV=4 and DEBOUNCE=3.
- **Reset and tick.** Release reset → `o_tick` pulses at cycles 3, 7, 11; all outputs stay 0.
- **Fault qualification.** Set `i_raw[2]` high and hold → `o_status[2]`, `o_fault_latched[2]` and `o_first_fault` = 0b0000100 all rise together on the third tick sample taken after synchronization. `o_any_fault` = 1 one cycle later.
- **Glitch rejection.** Pulse `i_raw[5]` high for exactly 2 tick samples, then low → `o_status` stays 0 and the counter returns to 0.
- **Ack while active / after clear.**
  - Assert `i_ack` while `o_status[2]` = 1 → latch and first fault are retained.
  - Drop `i_raw[2]`, wait for `o_status[2]` = 0, then assert `i_ack` → latch, `o_any_fault` and `o_first_valid` clear.
- **Simultaneous and later faults.**
  - Raise `i_raw[0]` and `i_raw[6]` in the same cycle → `o_first_fault` = 0b1000001.
  - A later `i_raw[3]` fault sets `o_fault_latched[3]` but leaves `o_first_fault` unchanged.
- **Reset mid-debounce.** Assert reset after 2 differing ticks on channel 1, then release with `i_raw[1]` still high → 3 fresh tick samples are needed before `o_status[1]` = 1.
